// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the memory arbiter and the
// single-port memory it fronts.
interface mem_arbiter_if #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 9
);
    logic                  if_req_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic                  if_gnt_o;
    logic                  if_rvalid_o;
    logic [XLEN-1:0]       if_rdata_o;

    logic                  dm_req_i;
    logic                  dm_we_i;
    logic [ADDR_WIDTH-1:0] dm_addr_i;
    logic [XLEN-1:0]       dm_wdata_i;
    logic                  dm_gnt_o;
    logic                  dm_rvalid_o;
    logic [XLEN-1:0]       dm_rdata_o;

    logic                  mem_en_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [XLEN-1:0]       mem_wdata_o;
    logic [XLEN-1:0]       mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, mem_rdata_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, dm_gnt_o, dm_rvalid_o, dm_rdata_o,
               mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, mem_rdata_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, dm_gnt_o, dm_rvalid_o, dm_rdata_o,
               mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one single-port memory: data wins, fetch is forced
// through after STARVE_LIMIT consecutive data grants; responses one cycle later.
module mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int ADDR_WIDTH   = 9,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int              CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]   LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, RSP_IF, RSP_DM} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          dm_we_q, dm_we_d;
    logic          if_gnt, dm_gnt;

    // Grants are combinational and forced low while reset is held.
    always_comb begin
        if_gnt = !rst && bus.if_req_i && (!bus.dm_req_i || (starve_q == LIMIT));
        dm_gnt = !rst && bus.dm_req_i && !if_gnt;
    end

    always_comb begin
        bus.if_gnt_o    = if_gnt;
        bus.dm_gnt_o    = dm_gnt;
        bus.mem_en_o    = if_gnt | dm_gnt;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = bus.if_addr_i;
        bus.mem_wdata_o = bus.dm_wdata_i;
        if (dm_gnt) begin
            bus.mem_we_o   = bus.dm_we_i;
            bus.mem_addr_o = bus.dm_addr_i;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!bus.if_req_i || if_gnt) begin
            starve_d = '0;
        end else if (dm_gnt && (starve_q != LIMIT)) begin
            starve_d = starve_q + CW'(1);
        end
    end

    // Next state follows this cycle's grant; the write flag is remembered so
    // a completed write returns zero data.
    always_comb begin
        state_d         = IDLE;
        dm_we_d         = 1'b0;
        bus.if_rvalid_o = 1'b0;
        bus.if_rdata_o  = '0;
        bus.dm_rvalid_o = 1'b0;
        bus.dm_rdata_o  = '0;
        if (dm_gnt) begin
            state_d = RSP_DM;
            dm_we_d = bus.dm_we_i;
        end else if (if_gnt) begin
            state_d = RSP_IF;
        end
        case (state_q)
            RSP_IF: begin
                bus.if_rvalid_o = 1'b1;
                bus.if_rdata_o  = bus.mem_rdata_i;
            end
            RSP_DM: begin
                bus.dm_rvalid_o = 1'b1;
                bus.dm_rdata_o  = dm_we_q ? '0 : bus.mem_rdata_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
            dm_we_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            dm_we_q  <= dm_we_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: the driver checks grants and queues the
// expected response; a negedge monitor pops and compares every rvalid.
module tb_mem_arbiter;
    localparam int XLEN = 32;
    localparam int AW   = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.XLEN(XLEN), .ADDR_WIDTH(AW)) bus ();

    mem_arbiter #(.XLEN(XLEN), .ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Environment memory and an independent shadow used for expected data.
    logic [XLEN-1:0] mem    [0:(1<<AW)-1];
    logic [XLEN-1:0] shadow [0:(1<<AW)-1];
    logic [XLEN-1:0] rdata_q = '0;
    assign bus.mem_rdata_i = rdata_q;
    always @(posedge clk) begin
        if (bus.mem_en_o) begin
            if (bus.mem_we_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
            else              rdata_q <= mem[bus.mem_addr_o];
        end
    end

    int tests = 0;
    int fails = 0;
    logic [XLEN-1:0] if_q[$];
    logic [XLEN-1:0] dm_q[$];
    int ref_starve = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive at posedge+1, check grants/mux at posedge+4.
    task automatic drive(input logic ir, input logic [AW-1:0] ia,
                         input logic dr, input logic dw, input logic [AW-1:0] da,
                         input logic [XLEN-1:0] dwd,
                         input logic eig, input logic edg, input logic [XLEN-1:0] exp_data,
                         input string name);
        @(posedge clk);
        #1;
        bus.if_req_i = ir;  bus.if_addr_i = ia;
        bus.dm_req_i = dr;  bus.dm_we_i = dw; bus.dm_addr_i = da; bus.dm_wdata_i = dwd;
        #3;
        check({name, ".if_gnt"}, XLEN'(bus.if_gnt_o), XLEN'(eig));
        check({name, ".dm_gnt"}, XLEN'(bus.dm_gnt_o), XLEN'(edg));
        if (edg) begin
            check({name, ".mem_addr"}, XLEN'(bus.mem_addr_o), XLEN'(da));
            check({name, ".mem_we"}, XLEN'(bus.mem_we_o), XLEN'(dw));
            if (dw) check({name, ".mem_wdata"}, bus.mem_wdata_o, dwd);
            dm_q.push_back(exp_data);
        end else if (eig) begin
            check({name, ".mem_addr"}, XLEN'(bus.mem_addr_o), XLEN'(ia));
            check({name, ".mem_we"}, XLEN'(bus.mem_we_o), '0);
            if_q.push_back(exp_data);
        end
        if (!ir || eig)                     ref_starve = 0;
        else if (edg && ref_starve != 4)    ref_starve++;
    endtask

    always @(negedge clk) begin
        check("grant_overlap", XLEN'(bus.if_gnt_o & bus.dm_gnt_o), '0);
        check("mem_en", XLEN'(bus.mem_en_o), XLEN'(bus.if_gnt_o | bus.dm_gnt_o));
        if (bus.if_rvalid_o) begin
            if (if_q.size() == 0) check("if_unexpected_rvalid", 1, 0);
            else                  check("if_rdata", bus.if_rdata_o, if_q.pop_front());
        end else begin
            check("if_rdata_idle", bus.if_rdata_o, '0);
        end
        if (bus.dm_rvalid_o) begin
            if (dm_q.size() == 0) check("dm_unexpected_rvalid", 1, 0);
            else                  check("dm_rdata", bus.dm_rdata_o, dm_q.pop_front());
        end else begin
            check("dm_rdata_idle", bus.dm_rdata_o, '0);
        end
    end

    task automatic check_reset_outputs(input string name);
        check({name, ".if_gnt"},    XLEN'(bus.if_gnt_o), '0);
        check({name, ".dm_gnt"},    XLEN'(bus.dm_gnt_o), '0);
        check({name, ".mem_en"},    XLEN'(bus.mem_en_o), '0);
        check({name, ".mem_we"},    XLEN'(bus.mem_we_o), '0);
        check({name, ".if_rvalid"}, XLEN'(bus.if_rvalid_o), '0);
        check({name, ".dm_rvalid"}, XLEN'(bus.dm_rvalid_o), '0);
        check({name, ".starve"},    XLEN'(dut.starve_q), '0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, '0, 0, 0, '0, '0, 0, 0, '0, "idle");
    endtask

    initial begin
        logic ir, dr, dw, eig, edg;
        logic [AW-1:0] ia, da;
        logic [XLEN-1:0] wd, ed;

        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]    = 32'hA000_0000 | i;
            shadow[i] = 32'hA000_0000 | i;
        end
        mem[9'h010] = 32'h0050_0093;  shadow[9'h010] = 32'h0050_0093;
        mem[9'h100] = 32'h1234_5678;  shadow[9'h100] = 32'h1234_5678;

        bus.if_req_i = 0; bus.if_addr_i = '0; bus.dm_req_i = 0;
        bus.dm_we_i = 0;  bus.dm_addr_i = '0; bus.dm_wdata_i = '0;

        // Requests asserted under reset must be ignored.
        #2 bus.if_req_i = 1; bus.dm_req_i = 1;
        #5 check_reset_outputs("reset");
        #5 bus.if_req_i = 0; bus.dm_req_i = 0; rst = 0;

        drive(1, 9'h010, 0, 0, '0, '0, 1, 0, 32'h0050_0093, "fetch_only");
        drive(1, 9'h020, 1, 0, 9'h100, '0, 0, 1, 32'h1234_5678, "conflict_dm");
        drive(1, 9'h020, 0, 0, '0, '0, 1, 0, 32'hA000_0020, "conflict_if");

        for (int k = 0; k < 10; k++) begin
            eig = (k == 4) || (k == 9);
            ed  = eig ? 32'hA000_0030 : (32'hA000_0040 + k);
            drive(1, 9'h030, 1, 0, 9'(9'h040 + k), '0, eig, !eig, ed, $sformatf("starve%0d", k));
        end

        drive(0, '0, 1, 1, 9'h1FF, 32'hDEAD_BEEF, 0, 1, '0, "wr_1ff");
        shadow[9'h1FF] = 32'hDEAD_BEEF;
        drive(0, '0, 1, 0, 9'h1FF, '0, 0, 1, 32'hDEAD_BEEF, "rd_1ff");
        idle(1);

        // Reset during a pending data response with a non-zero starve count.
        drive(1, 9'h060, 1, 0, 9'h050, '0, 0, 1, 32'hA000_0050, "rstdm_a");
        drive(1, 9'h060, 1, 0, 9'h050, '0, 0, 1, 32'hA000_0050, "rstdm_b");
        drive(1, 9'h060, 1, 0, 9'h050, '0, 0, 1, 32'hA000_0050, "rstdm_c");
        #2 rst = 1; void'(dm_q.pop_back()); ref_starve = 0;
        #1 check_reset_outputs("rst_mid_dm");
        @(posedge clk); #1 check_reset_outputs("rst_mid_dm_hold");
        bus.if_req_i = 0; bus.dm_req_i = 0;
        @(posedge clk); #2 rst = 0;

        // Reset during a pending fetch response.
        drive(1, 9'h070, 0, 0, '0, '0, 1, 0, 32'hA000_0070, "rstif");
        #2 rst = 1; void'(if_q.pop_back()); ref_starve = 0;
        #1 check_reset_outputs("rst_mid_if");
        bus.if_req_i = 0;
        @(posedge clk); #2 rst = 0;
        idle(1);
        drive(1, 9'h010, 0, 0, '0, '0, 1, 0, 32'h0050_0093, "post_rst_fetch");

        // Mixed traffic: expected grants from a reference starve counter.
        for (int n = 0; n < 200; n++) begin
            ir  = 1'($urandom_range(0, 1));
            dr  = ($urandom_range(0, 3) != 0);
            dw  = 1'($urandom_range(0, 1));
            ia  = 9'($urandom_range(0, 31));
            da  = 9'($urandom_range(0, 31));
            wd  = $urandom;
            eig = ir && (!dr || ref_starve == 4);
            edg = dr && !eig;
            ed  = edg ? (dw ? '0 : shadow[da]) : shadow[ia];
            drive(ir, ia, dr, dw, da, wd, eig, edg, ed, $sformatf("mix%0d", n));
            if (edg && dw) shadow[da] = wd;
        end

        idle(3);
        check("if_queue_drained", XLEN'(if_q.size()), '0);
        check("dm_queue_drained", XLEN'(dm_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: XLEN, default 32, data word width.
REQ-002 Parameter: ADDR_WIDTH, default 9, word-address width (memory holds 2**ADDR_WIDTH words).
REQ-003 Parameter: STARVE_LIMIT, default 4, maximum consecutive data grants while a fetch waits.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 if_req_i  input  1  fetch-stage read request.
REQ-007 if_addr_i  input  ADDR_WIDTH  fetch word address.
REQ-008 if_gnt_o  output  1  fetch request accepted this cycle (combinational).
REQ-009 if_rvalid_o  output  1  fetch read data valid.
REQ-010 if_rdata_o  output  XLEN  fetch read data.
REQ-011 dm_req_i  input  1  memory-stage access request.
REQ-012 dm_we_i  input  1  1 = write, 0 = read.
REQ-013 dm_addr_i  input  ADDR_WIDTH  data word address.
REQ-014 dm_wdata_i  input  XLEN  write data.
REQ-015 dm_gnt_o  output  1  data request accepted this cycle (combinational).
REQ-016 dm_rvalid_o  output  1  data access complete; read data valid if read.
REQ-017 dm_rdata_o  output  XLEN  data read data.
REQ-018 mem_en_o / mem_we_o  output  1 / 1  single-port memory enable / write enable.
REQ-019 mem_addr_o / mem_wdata_o  output  ADDR_WIDTH / XLEN  memory address / write data.
REQ-020 mem_rdata_i  input  XLEN  memory read data, valid one cycle after mem_en_o=1 with mem_we_o=0.

Function
REQ-021 At most one of if_gnt_o, dm_gnt_o SHALL be 1 in any cycle; mem_en_o SHALL equal if_gnt_o | dm_gnt_o.
REQ-022 Memory port mux: dm grant -> mem_addr_o=dm_addr_i, mem_we_o=dm_we_i, mem_wdata_o=dm_wdata_i; if grant -> mem_addr_o=if_addr_i, mem_we_o=0; no grant -> mem_we_o=0.
REQ-023 Arbitration: data has priority; fetch is granted when dm_req_i=0, or when starve_cnt==STARVE_LIMIT and if_req_i=1.
REQ-024 starve_cnt (saturating, width clog2(STARVE_LIMIT+1)) SHALL increment on each dm grant while if_req_i=1, and clear on if grant or any cycle with if_req_i=0.
REQ-025 Requesters hold req/addr/we/wdata stable until the grant cycle; the arbiter does not check this.
REQ-026 Response FSM states: IDLE, RSP_IF, RSP_DM; next state = RSP_DM on dm grant, RSP_IF on if grant, else IDLE; transitions every cycle without bubbles.
REQ-027 In RSP_IF: if_rvalid_o=1, if_rdata_o=mem_rdata_i; in RSP_DM: dm_rvalid_o=1, dm_rdata_o=mem_rdata_i for reads, dm_rdata_o=0 for writes.
REQ-028 Latency: grant in cycle N -> rvalid in cycle N+1, exactly one pulse per grant; back-to-back grants yield back-to-back rvalids.
REQ-029 rdata outputs SHALL be 0 whenever the matching rvalid is 0.
REQ-030 A write granted in cycle N SHALL be visible to a read granted in cycle N+1 (memory write-first not required, same-cycle not possible).
REQ-031 Simultaneous requests with starve_cnt<STARVE_LIMIT: dm granted, if_gnt_o=0 (fetch stalls).

Reset
REQ-032 While rst=1: state=IDLE, starve_cnt=0, all grant, rvalid, mem_en_o, mem_we_o outputs 0, rdata outputs 0.
REQ-033 Reset asserted between grant and response SHALL suppress that response; no rvalid after reset deassertion without a new grant.
REQ-034 First grant possible in the first rising edge cycle after rst deasserts.

Verification
REQ-035 Fetch only: if_req_i=1, addr=0x010, mem[0x010]=0x00500093 -> if_gnt_o=1 cycle N, if_rvalid_o=1, if_rdata_o=0x00500093 cycle N+1.
REQ-036 Conflict: if_req_i=dm_req_i=1, dm read 0x100 -> dm_gnt_o=1, if_gnt_o=0; next cycle dm_rvalid_o=1; fetch granted once dm_req_i drops.
REQ-037 Starvation: if_req_i=1 and dm_req_i=1 held 10 cycles, STARVE_LIMIT=4 -> grant pattern DM,DM,DM,DM,IF,DM,DM,DM,DM,IF.
REQ-038 Write-then-read: dm write 0x1FF=0xDEADBEEF cycle N, dm read 0x1FF cycle N+1 -> dm_rvalid_o cycle N+1 with rdata 0, cycle N+2 with rdata 0xDEADBEEF.
REQ-039 Reset mid-operation: if grant cycle N, rst=1 asynchronously before edge N+1 -> if_rvalid_o=0 throughout and after reset; starve_cnt=0.
REQ-040 Random mixed traffic: per requester, count(rvalid) == count(gnt), grants never overlap, responses in order.
